// File: rtl/sdram_burst_tester.sv
// Avalon-MM burst master that writes a deterministic pattern to SDRAM, reads it back and counts errors.
// Define SDRAM_TESTER_LFSR_EN to take data from a 16-bit LFSR instead of address ^ 16'h5A5A.
module sdram_burst_tester #(
  parameter logic [21:0] START_ADDR = 22'd0,
  parameter int          BURST      = 8,
  parameter int          NUM_BURSTS = 1024,
  parameter int          TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        m_read,
  output logic        m_write,
  output logic [21:0] m_address,
  output logic [15:0] m_writedata,
  output logic [8:0]  m_burstcount,
  output logic [1:0]  m_byteenable,
  input  logic        m_waitrequest,
  input  logic        m_readdatavalid,
  input  logic [15:0] m_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [21:0] first_err_addr
);
  typedef enum logic [2:0] {IDLE, WR_BEAT, WR_GAP, RD_CMD, RD_DATA, FINISH} state_t;

  localparam logic [8:0]  BEAT_LAST  = 9'(BURST - 1);
  localparam logic [15:0] BURST_LAST = 16'(NUM_BURSTS - 1);
  localparam logic [21:0] BURST_STEP = 22'(BURST);
  localparam int          TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state_reg;
  logic [21:0]   base_reg;
  logic [8:0]    beat_reg;
  logic [15:0]   burst_reg;
  logic [TW-1:0] tmo_reg;

  logic [21:0] next_base, rd_addr, addr_inc, err_addr;
  logic [15:0] first_wr_data, next_wr_data, gap_wr_data, exp_data;
  logic        rd_beat, rd_last, mismatch, timeout, stray_rdv, stray_ack;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  assign m_burstcount = 9'(BURST);
  assign m_byteenable = 2'b11;

  assign next_base = base_reg + BURST_STEP;
  assign rd_addr   = base_reg + {13'd0, beat_reg};
  assign addr_inc  = m_address + 22'd1;

`ifdef SDRAM_TESTER_LFSR_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr_reg;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  // Reseeded at the start of each phase, stepped per accepted write / received read beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      lfsr_reg <= LFSR_SEED;
    else if (state_reg == IDLE && start)
      lfsr_reg <= LFSR_SEED;
    else if (state_reg == WR_BEAT && !m_waitrequest)
      lfsr_reg <= lfsr_step(lfsr_reg);
    else if (state_reg == WR_GAP && burst_reg == BURST_LAST)
      lfsr_reg <= LFSR_SEED;
    else if (rd_beat)
      lfsr_reg <= lfsr_step(lfsr_reg);
  end

  assign first_wr_data = LFSR_SEED;
  assign next_wr_data  = lfsr_step(lfsr_reg);
  assign gap_wr_data   = lfsr_reg;
  assign exp_data      = lfsr_reg;
`else
  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  assign first_wr_data = pat(START_ADDR[15:0]);
  assign next_wr_data  = pat(addr_inc[15:0]);
  assign gap_wr_data   = pat(next_base[15:0]);
  assign exp_data      = pat(rd_addr[15:0]);
`endif

  assign rd_beat   = (state_reg == RD_DATA) && m_readdatavalid;
  assign rd_last   = rd_beat && (beat_reg == BEAT_LAST);
  assign mismatch  = rd_beat && (m_readdata != exp_data);
  assign timeout   = (state_reg == RD_DATA) && !rd_last && (tmo_reg == TMO_LAST);
  assign stray_rdv = (state_reg != RD_DATA) && m_readdatavalid;
  assign stray_ack = (state_reg == IDLE) && !m_waitrequest;
  assign err_inc   = {1'b0, mismatch} + {1'b0, timeout} + {1'b0, stray_rdv} + {1'b0, stray_ack};
  assign err_sum   = {1'b0, err_count} + {15'd0, err_inc};
  assign err_addr  = (mismatch || timeout) ? rd_addr : m_address;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      base_reg       <= 22'd0;
      beat_reg       <= 9'd0;
      burst_reg      <= 16'd0;
      tmo_reg        <= '0;
      m_read         <= 1'b0;
      m_write        <= 1'b0;
      m_address      <= 22'd0;
      m_writedata    <= 16'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 16'd0;
      first_err_addr <= 22'd0;
    end else begin
      // Error accounting first so that a starting run's clear below takes priority.
      if (err_inc != 2'd0) begin
        err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (err_count == 16'd0)
          first_err_addr <= err_addr;
      end
      case (state_reg)
        IDLE: if (start) begin
          state_reg      <= WR_BEAT;
          busy           <= 1'b1;
          done           <= 1'b0;
          pass           <= 1'b0;
          err_count      <= 16'd0;
          first_err_addr <= 22'd0;
          base_reg       <= START_ADDR;
          beat_reg       <= 9'd0;
          burst_reg      <= 16'd0;
          m_write        <= 1'b1;
          m_address      <= START_ADDR;
          m_writedata    <= first_wr_data;
        end
        WR_BEAT: if (!m_waitrequest) begin
          if (beat_reg == BEAT_LAST) begin
            m_write   <= 1'b0;
            state_reg <= WR_GAP;
          end else begin
            beat_reg    <= beat_reg + 9'd1;
            m_address   <= addr_inc;
            m_writedata <= next_wr_data;
          end
        end
        WR_GAP: begin
          beat_reg <= 9'd0;
          if (burst_reg == BURST_LAST) begin
            burst_reg <= 16'd0;
            base_reg  <= START_ADDR;
            m_address <= START_ADDR;
            m_read    <= 1'b1;
            state_reg <= RD_CMD;
          end else begin
            burst_reg   <= burst_reg + 16'd1;
            base_reg    <= next_base;
            m_address   <= next_base;
            m_writedata <= gap_wr_data;
            m_write     <= 1'b1;
            state_reg   <= WR_BEAT;
          end
        end
        RD_CMD: if (!m_waitrequest) begin
          m_read    <= 1'b0;
          tmo_reg   <= '0;
          beat_reg  <= 9'd0;
          state_reg <= RD_DATA;
        end
        RD_DATA: begin
          tmo_reg <= tmo_reg + TW'(1);
          if (rd_beat)
            beat_reg <= beat_reg + 9'd1;
          // A timed-out burst is abandoned; the next burst is still issued.
          if (rd_last || timeout) begin
            beat_reg <= 9'd0;
            if (burst_reg == BURST_LAST) begin
              state_reg <= FINISH;
            end else begin
              burst_reg <= burst_reg + 16'd1;
              base_reg  <= next_base;
              m_address <= next_base;
              m_read    <= 1'b1;
              state_reg <= RD_CMD;
            end
          end
        end
        FINISH: begin
          busy      <= 1'b0;
          done      <= 1'b1;
          pass      <= (err_count == 16'd0) && (err_inc == 2'd0);
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_burst_tester.sv
// Bench for sdram_burst_tester: two parameterisations share one behavioural Avalon slave (read latency 3)
// and results are checked against expected bus traffic computed directly from the region parameters.
module tb_sdram_burst_tester;
  localparam logic [21:0] A_START = 22'd0;
  localparam logic [21:0] B_START = 22'h3FFFF8;
  localparam int BURST = 8;
  localparam int A_NB  = 4;
  localparam int B_NB  = 2;
  localparam int TMO   = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start_w [2];
  logic        wait_w  [2];
  logic        rdv_w   [2];
  logic        m_read_w [2];
  logic        m_write_w [2];
  logic        busy_w [2];
  logic        done_w [2];
  logic        pass_w [2];
  logic [21:0] addr_w [2];
  logic [21:0] ferr_w [2];
  logic [15:0] wdata_w [2];
  logic [15:0] err_w [2];
  logic [8:0]  bc_w [2];
  logic [1:0]  be_w [2];

  logic        sel = 1'b0;
  logic        s_wait = 1'b1;
  logic        s_rdv = 1'b0;
  logic [15:0] s_rdata = 16'd0;
  logic        stall_en = 1'b0, flip_en = 1'b0, nodata_en = 1'b0, idle_ack = 1'b0, stray_en = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {int due; logic [21:0] addr;} beat_t;
  beat_t       pend_q[$];
  logic [15:0] mem [logic [21:0]];
  logic [21:0] wr_addr_q[$], rd_cmd_q[$], exp_wa[$], exp_rd[$];
  logic [15:0] wr_data_q[$], exp_wd[$];

  assign wait_w[0] = sel ? 1'b1 : s_wait;
  assign wait_w[1] = sel ? s_wait : 1'b1;
  assign rdv_w[0]  = sel ? 1'b0 : s_rdv;
  assign rdv_w[1]  = sel ? s_rdv : 1'b0;

  logic        bus_read, bus_write;
  logic [21:0] bus_addr;
  logic [15:0] bus_wdata;
  assign bus_read  = sel ? m_read_w[1]  : m_read_w[0];
  assign bus_write = sel ? m_write_w[1] : m_write_w[0];
  assign bus_addr  = sel ? addr_w[1]    : addr_w[0];
  assign bus_wdata = sel ? wdata_w[1]   : wdata_w[0];

  sdram_burst_tester #(.START_ADDR(A_START), .BURST(BURST), .NUM_BURSTS(A_NB), .TIMEOUT(TMO)) dut_a (
    .clk(clk), .reset(reset), .start(start_w[0]), .m_read(m_read_w[0]), .m_write(m_write_w[0]),
    .m_address(addr_w[0]), .m_writedata(wdata_w[0]), .m_burstcount(bc_w[0]), .m_byteenable(be_w[0]),
    .m_waitrequest(wait_w[0]), .m_readdatavalid(rdv_w[0]), .m_readdata(s_rdata),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err_w[0]), .first_err_addr(ferr_w[0]));

  sdram_burst_tester #(.START_ADDR(B_START), .BURST(BURST), .NUM_BURSTS(B_NB), .TIMEOUT(TMO)) dut_b (
    .clk(clk), .reset(reset), .start(start_w[1]), .m_read(m_read_w[1]), .m_write(m_write_w[1]),
    .m_address(addr_w[1]), .m_writedata(wdata_w[1]), .m_burstcount(bc_w[1]), .m_byteenable(be_w[1]),
    .m_waitrequest(wait_w[1]), .m_readdatavalid(rdv_w[1]), .m_readdata(s_rdata),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err_w[1]), .first_err_addr(ferr_w[1]));

  // Slave: decides at each falling edge what the DUT will see at the next rising edge.
  always @(negedge clk) begin
    beat_t b;
    cyc = cyc + 1;
    if (reset) begin
      pend_q.delete();
      s_wait = 1'b1;
      s_rdv = 1'b0;
    end else begin
      if (!(bus_read || bus_write)) s_wait = !idle_ack;
      else s_wait = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
      if (!s_wait && bus_write) begin
        mem[bus_addr] = bus_wdata;
        wr_addr_q.push_back(bus_addr);
        wr_data_q.push_back(bus_wdata);
      end
      if (!s_wait && bus_read) begin
        rd_cmd_q.push_back(bus_addr);
        if (!nodata_en)
          for (int k = 0; k < BURST; k++) begin
            b.due = cyc + 3 + k;
            b.addr = bus_addr + 22'(k);
            pend_q.push_back(b);
          end
      end
      s_rdv = stray_en;
      s_rdata = 16'd0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        b = pend_q.pop_front();
        s_rdv = 1'b1;
        s_rdata = mem.exists(b.addr) ? mem[b.addr] : 16'hDEAD;
        if (flip_en && b.addr == 22'd13) s_rdata[0] = ~s_rdata[0];
      end
    end
  end

  // Expected traffic: NB bursts of BURST consecutive words from base, modulo 2^22.
  task automatic build_model(input logic [21:0] base, input int nb);
    logic [21:0] a;
`ifdef SDRAM_TESTER_LFSR_EN
    logic [15:0] lf = 16'hACE1;
`endif
    exp_wa.delete(); exp_wd.delete(); exp_rd.delete();
    for (int b = 0; b < nb; b++) begin
      exp_rd.push_back(base + 22'(b * BURST));
      for (int k = 0; k < BURST; k++) begin
        a = base + 22'(b * BURST + k);
        exp_wa.push_back(a);
`ifdef SDRAM_TESTER_LFSR_EN
        exp_wd.push_back(lf);
        lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
`else
        exp_wd.push_back(a[15:0] ^ 16'h5A5A);
`endif
      end
    end
  endtask

  function automatic int seq_diffs();
    int d = 0;
    if (wr_addr_q.size() != exp_wa.size()) d++;
    if (rd_cmd_q.size() != exp_rd.size()) d++;
    for (int i = 0; i < exp_wa.size() && i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] !== exp_wa[i] || wr_data_q[i] !== exp_wd[i]) d++;
    for (int i = 0; i < exp_rd.size() && i < rd_cmd_q.size(); i++)
      if (rd_cmd_q[i] !== exp_rd[i]) d++;
    return d;
  endfunction

  task automatic set_mode(input logic s, input logic stall, input logic flip, input logic nodata);
    @(posedge clk); #2;
    sel = s; stall_en = stall; flip_en = flip; nodata_en = nodata;
  endtask

  task automatic pulse_start();
    wr_addr_q.delete(); wr_data_q.delete(); rd_cmd_q.delete();
    @(negedge clk);
    start_w[sel] = 1'b1;
    @(negedge clk);
    start_w[sel] = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done_w[sel]) begin
        timed_out = 1'b0;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (m_read_w[0] !== 1'b0 || m_write_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || pass_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got rd=%b wr=%b busy=%b done=%b pass=%b want all 0", m_read_w[0], m_write_w[0], busy_w[0], done_w[0], pass_w[0]);
    end
    checks++;
    if (addr_w[0] !== 22'd0 || wdata_w[0] !== 16'd0 || err_w[0] !== 16'd0 || ferr_w[0] !== 22'd0) begin
      failures++;
      $display("FAIL reset_data got addr=%h wdata=%h err=%h ferr=%h want 0", addr_w[0], wdata_w[0], err_w[0], ferr_w[0]);
    end
    checks++;
    if (bc_w[0] !== 9'd8 || be_w[0] !== 2'b11 || bc_w[1] !== 9'd8 || be_w[1] !== 2'b11) begin
      failures++;
      $display("FAIL reset_const got bc=%0d/%0d be=%b/%b want 8 and 11", bc_w[0], bc_w[1], be_w[0], be_w[1]);
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_ideal();
    bit to;
    int d;
    set_mode(1'b0, 1'b0, 1'b0, 1'b0);
    build_model(A_START, A_NB);
    pulse_start();
    checks++;
    if (m_write_w[0] !== 1'b1 || busy_w[0] !== 1'b1 || done_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL ideal_first_write got wr=%b busy=%b done=%b want 1 1 0", m_write_w[0], busy_w[0], done_w[0]);
    end
    wait_done(2000, to);
    checks++;
    if (to) begin failures++; $display("FAIL ideal_done got timeout want done"); end
    d = seq_diffs();
    checks++;
    if (d != 0) begin
      failures++;
      $display("FAIL ideal_seq got %0d diffs (writes=%0d reads=%0d) want 0 (writes=32 reads=4)", d, wr_addr_q.size(), rd_cmd_q.size());
    end
    checks++;
    if (pass_w[0] !== 1'b1 || err_w[0] !== 16'd0 || busy_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL ideal_result got pass=%b err=%0d busy=%b want 1 0 0", pass_w[0], err_w[0], busy_w[0]);
    end
    $display("ideal: writes=%0d reads=%0d err=%0d pass=%b", wr_addr_q.size(), rd_cmd_q.size(), err_w[0], pass_w[0]);
  endtask

  task automatic test_protocol();
    @(posedge clk); #2 idle_ack = 1'b1;
    @(posedge clk); #2 idle_ack = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (err_w[0] !== 16'd1 || done_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL idle_ack_err got err=%0d done=%b want 1 1", err_w[0], done_w[0]);
    end
    @(posedge clk); #2 stray_en = 1'b1;
    @(posedge clk); #2 stray_en = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (err_w[0] !== 16'd2) begin
      failures++;
      $display("FAIL stray_rdv_err got err=%0d want 2", err_w[0]);
    end
    $display("protocol: err=%0d", err_w[0]);
  endtask

  task automatic test_bitflip();
    bit to;
    set_mode(1'b0, 1'b0, 1'b1, 1'b0);
    pulse_start();
    wait_done(2000, to);
    checks++;
    if (to || err_w[0] !== 16'd1 || ferr_w[0] !== 22'd13 || pass_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL bitflip got to=%b err=%0d ferr=%0d pass=%b want 0 1 13 0", to, err_w[0], ferr_w[0], pass_w[0]);
    end
    $display("bitflip: err=%0d first_err_addr=%0d pass=%b", err_w[0], ferr_w[0], pass_w[0]);
  endtask

  task automatic test_stall();
    bit to;
    int d;
    set_mode(1'b0, 1'b1, 1'b0, 1'b0);
    build_model(A_START, A_NB);
    pulse_start();
    repeat (20) @(negedge clk);
    start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    wait_done(4000, to);
    d = seq_diffs();
    checks++;
    if (to || d != 0) begin
      failures++;
      $display("FAIL stall_seq got to=%b diffs=%0d writes=%0d want 0 0 32", to, d, wr_addr_q.size());
    end
    checks++;
    if (pass_w[0] !== 1'b1 || err_w[0] !== 16'd0) begin
      failures++;
      $display("FAIL stall_result got pass=%b err=%0d want 1 0", pass_w[0], err_w[0]);
    end
    $display("stall: writes=%0d reads=%0d pass=%b", wr_addr_q.size(), rd_cmd_q.size(), pass_w[0]);
    set_mode(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    bit to;
    int d;
    set_mode(1'b1, 1'b0, 1'b0, 1'b0);
    build_model(B_START, B_NB);
    pulse_start();
    wait_done(2000, to);
    d = seq_diffs();
    checks++;
    if (to || d != 0) begin
      failures++;
      $display("FAIL wrap_seq got to=%b diffs=%0d want 0 0", to, d);
    end
    checks++;
    if (rd_cmd_q.size() < 2 || rd_cmd_q[1] !== 22'd0 || wr_addr_q.size() < 9 || wr_addr_q[8] !== 22'd0) begin
      failures++;
      $display("FAIL wrap_second_burst got reads=%0d writes=%0d want second burst at 0", rd_cmd_q.size(), wr_addr_q.size());
    end
    checks++;
    if (pass_w[1] !== 1'b1 || busy_w[1] !== 1'b0) begin
      failures++;
      $display("FAIL wrap_result got pass=%b busy=%b want 1 0", pass_w[1], busy_w[1]);
    end
    $display("wrap: writes=%0d reads=%0d pass=%b", wr_addr_q.size(), rd_cmd_q.size(), pass_w[1]);
  endtask

  task automatic test_timeout();
    bit to;
    set_mode(1'b1, 1'b0, 1'b0, 1'b1);
    pulse_start();
    wait_done(1000, to);
    checks++;
    if (to || done_w[1] !== 1'b1 || err_w[1] !== 16'd2 || ferr_w[1] !== B_START || pass_w[1] !== 1'b0) begin
      failures++;
      $display("FAIL timeout got to=%b done=%b err=%0d ferr=%h pass=%b want 0 1 2 3ffff8 0", to, done_w[1], err_w[1], ferr_w[1], pass_w[1]);
    end
    checks++;
    if (rd_cmd_q.size() != 2) begin
      failures++;
      $display("FAIL timeout_reads got %0d read commands want 2", rd_cmd_q.size());
    end
    $display("timeout: err=%0d first_err_addr=%h", err_w[1], ferr_w[1]);
    set_mode(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit to;
    int reqs = 0;
    int d;
    set_mode(1'b0, 1'b0, 1'b0, 1'b0);
    pulse_start();
    for (int i = 0; i < 300 && rd_cmd_q.size() < 2; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy_w[0] !== 1'b0 || m_read_w[0] !== 1'b0 || m_write_w[0] !== 1'b0 || rd_cmd_q.size() < 2) begin
      failures++;
      $display("FAIL reset_mid got busy=%b rd=%b wr=%b reads=%0d want 0 0 0 >=2", busy_w[0], m_read_w[0], m_write_w[0], rd_cmd_q.size());
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (m_read_w[0] || m_write_w[0]) reqs++;
    end
    checks++;
    if (reqs != 0) begin failures++; $display("FAIL reset_quiet got %0d request cycles want 0", reqs); end
    build_model(A_START, A_NB);
    pulse_start();
    wait_done(2000, to);
    d = seq_diffs();
    checks++;
    if (to || d != 0 || pass_w[0] !== 1'b1 || err_w[0] !== 16'd0) begin
      failures++;
      $display("FAIL rerun got to=%b diffs=%0d pass=%b err=%0d want 0 0 1 0", to, d, pass_w[0], err_w[0]);
    end
    $display("reset_mid: rerun pass=%b err=%0d", pass_w[0], err_w[0]);
  endtask

  initial begin
    start_w[0] = 1'b0;
    start_w[1] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    test_ideal();
    test_protocol();
    test_bitflip();
    test_stall();
    test_wrap();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
